// File: rtl/pipelined_muldiv_unit.sv
// pipelined_muldiv_unit: multi-cycle RISC-V M-extension multiply/divide unit with valid/ready handshake and tag pass-through.
// Optional MULDIV_DIVREM_CACHE_EN keeps the last full divide's quotient/remainder for a 1-edge paired DIV/REM.
`ifndef ALU_MUL
`define ALU_MUL    6'h20
`define ALU_MULH   6'h21
`define ALU_MULHSU 6'h22
`define ALU_MULHU  6'h23
`define ALU_DIV    6'h24
`define ALU_DIVU   6'h25
`define ALU_REM    6'h26
`define ALU_REMU   6'h27
`endif

module pipelined_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       alucode,
    input  logic [XLEN-1:0]  op1,
    input  logic [XLEN-1:0]  op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, quo_q, quo_d, result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;

    logic                     in_div, in_rem, in_sgn, in_m, dz, ovf, spec, hit;
    logic [XLEN-1:0]          spec_res, hit_res, m1, m2, quo_fix, rem_fix;
    logic                     is_mul, is_div, s1, s2;
    logic [2*XLEN-1:0]        prod_fix;
    logic [XLEN+MUL_BITS-1:0] pp, sum;
    logic [XLEN+1:0]          diff;

    assign in_div   = alucode inside {`ALU_DIV, `ALU_DIVU};
    assign in_rem   = alucode inside {`ALU_REM, `ALU_REMU};
    assign in_sgn   = alucode inside {`ALU_DIV, `ALU_REM};
    assign in_m     = alucode inside {`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU,
                                      `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU};
    assign dz       = (in_div || in_rem) && op2 == '0;
    assign ovf      = in_sgn && op1 == {1'b1, {(XLEN-1){1'b0}}} && op2 == '1;
    assign spec     = dz || ovf || !in_m;
    assign spec_res = dz ? (in_div ? '1 : op1) : ovf ? (in_div ? op1 : '0) : '0;

    assign is_mul = op_q inside {`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_MULHU};
    assign is_div = op_q inside {`ALU_DIV, `ALU_DIVU};
    assign s1     = op_q inside {`ALU_MUL, `ALU_MULH, `ALU_MULHSU, `ALU_DIV, `ALU_REM};
    assign s2     = op_q inside {`ALU_MUL, `ALU_MULH, `ALU_DIV, `ALU_REM};
    assign m1     = (s1 && op1_q[XLEN-1]) ? -op1_q : op1_q;
    assign m2     = (s2 && op2_q[XLEN-1]) ? -op2_q : op2_q;

    // a holds multiplicand/divisor, b holds multiplier (consumed from the LSB) or dividend (from the MSB)
    assign pp   = {{MUL_BITS{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q[MUL_BITS-1:0]};
    assign sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    assign diff = {rem_q, b_q[XLEN-1]} - {2'b00, a_q};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -quo_q : quo_q;
    assign rem_fix  = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

`ifdef MULDIV_DIVREM_CACHE_EN
    logic            c_vld_q, c_vld_d, c_sgn_q, c_sgn_d;
    logic [XLEN-1:0] c_op1_q, c_op1_d, c_op2_q, c_op2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;

    assign hit     = c_vld_q && (in_div || in_rem) && op1 == c_op1_q && op2 == c_op2_q && in_sgn == c_sgn_q;
    assign hit_res = in_div ? c_quo_q : c_rem_q;

    always_comb begin
        c_vld_d = c_vld_q;
        c_sgn_d = c_sgn_q;
        c_op1_d = c_op1_q;
        c_op2_d = c_op2_q;
        c_quo_d = c_quo_q;
        c_rem_d = c_rem_q;
        if (state_q == FIX && !is_mul && !flush) begin
            c_vld_d = 1'b1;
            c_sgn_d = s1;
            c_op1_d = op1_q;
            c_op2_d = op2_q;
            c_quo_d = quo_fix;
            c_rem_d = rem_fix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld_q <= 1'b0;
            c_sgn_q <= 1'b0;
            c_op1_q <= '0;
            c_op2_q <= '0;
            c_quo_q <= '0;
            c_rem_q <= '0;
        end else begin
            c_vld_q <= c_vld_d;
            c_sgn_q <= c_sgn_d;
            c_op1_q <= c_op1_d;
            c_op2_q <= c_op2_d;
            c_quo_q <= c_quo_d;
            c_rem_q <= c_rem_d;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            IDLE: if (in_valid && !flush) begin
                op_d  = alucode;
                tag_d = in_tag;
                op1_d = op1;
                op2_d = op2;
                state_d  = (spec || hit) ? DONE : PREP;
                result_d = spec ? spec_res : hit ? hit_res : result_q;
            end
            PREP: begin
                neg_d   = (s1 && op1_q[XLEN-1]) ^ (s2 && op2_q[XLEN-1]);
                rneg_d  = s1 && op1_q[XLEN-1];
                a_d     = is_mul ? m1 : m2;
                b_d     = is_mul ? m2 : m1;
                acc_d   = '0;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d   = is_mul ? {sum, acc_q[XLEN-1:MUL_BITS]} : acc_q;
                b_d     = is_mul ? b_q >> MUL_BITS : b_q << 1;
                rem_d   = is_mul ? rem_q : diff[XLEN+1] ? {rem_q[XLEN-1:0], b_q[XLEN-1]} : diff[XLEN:0];
                quo_d   = is_mul ? quo_q : {quo_q[XLEN-2:0], ~diff[XLEN+1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == (is_mul ? MUL_LAST : DIV_LAST)) ? FIX : CALC;
            end
            FIX: begin
                result_d = op_q == `ALU_MUL ? prod_fix[XLEN-1:0] : is_mul ? prod_fix[2*XLEN-1:XLEN] :
                           is_div ? quo_fix : rem_fix;
                state_d  = DONE;
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = state_q == IDLE && rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign result    = result_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_pipelined_muldiv_unit.sv
// tb_pipelined_muldiv_unit: directed scoreboard bench for pipelined_muldiv_unit at XLEN=32, MUL_BITS=4.
`ifndef ALU_MUL
`define ALU_MUL    6'h20
`define ALU_MULH   6'h21
`define ALU_MULHSU 6'h22
`define ALU_MULHU  6'h23
`define ALU_DIV    6'h24
`define ALU_DIVU   6'h25
`define ALU_REM    6'h26
`define ALU_REMU   6'h27
`endif

module tb_pipelined_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alucode = '0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  out_tag;
    logic        busy;

    int compared = 0;
    int mismatched = 0;
    logic [36:0] sb[$];

`ifdef MULDIV_DIVREM_CACHE_EN
    localparam int CL = 0;
`else
    localparam int CL = 34;
`endif

    pipelined_muldiv_unit #(.XLEN(32), .MUL_BITS(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .alucode(alucode), .op1(op1), .op2(op2), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Drive one request; inputs are scrambled right after the accept edge to prove they were registered.
    task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit push);
        @(negedge clk);
        alucode = code; op1 = a; op2 = b; in_tag = tag; in_valid = 1'b1;
        if (push) sb.push_back({exp, tag});
        @(posedge clk); #1;
        in_valid = 1'b0; alucode = 6'h3f; op1 = '1; op2 = '1; in_tag = '1;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        logic [36:0] e;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        if (sb.size() == 0) check({name, " scoreboard empty"}, 64'(0), 64'(1));
        else begin
            e = sb.pop_front();
            check({name, " result"}, 64'(result), 64'(e[36:5]));
            check({name, " out_tag"}, 64'(out_tag), 64'(e[4:0]));
        end
    endtask

    task automatic run(input string name, input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int lat);
        issue(code, a, b, tag, exp, 1'b1);
        wait_out(name, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset out_tag", 64'(out_tag), 64'(0));
        rst = 1'b1;
        #1 check("post-reset in_ready", 64'(in_ready), 64'(1));

        run("MUL", `ALU_MUL, 32'd7, 32'hFFFFFFFD, 5'h01, 32'hFFFFFFEB, 10);
        run("MULHU", `ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 10);
        run("MULH", `ALU_MULH, 32'h80000000, 32'h80000000, 5'h03, 32'h40000000, 10);
        run("MULHSU", `ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h04, 32'hFFFFFFFF, 10);

        run("DIV", `ALU_DIV, 32'hFFFFFFF9, 32'd2, 5'h05, 32'hFFFFFFFD, 34);
        run("REM", `ALU_REM, 32'hFFFFFFF9, 32'd2, 5'h06, 32'hFFFFFFFF, CL);
        run("DIVU", `ALU_DIVU, 32'd100, 32'd7, 5'h07, 32'd14, 34);
        run("REMU", `ALU_REMU, 32'd100, 32'd7, 5'h08, 32'd2, CL);

        // special cases appear on the accept edge itself
        run("DIVU by 0", `ALU_DIVU, 32'd5, 32'd0, 5'h09, 32'hFFFFFFFF, 0);
        run("REM by 0", `ALU_REM, 32'd5, 32'd0, 5'h0A, 32'd5, 0);
        run("DIV ovf", `ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'h80000000, 0);
        run("REM ovf", `ALU_REM, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'd0, 0);
        run("non-M", 6'h00, 32'd9, 32'd3, 5'h0D, 32'd0, 0);

        // signedness mismatch with cached DIVU entry forces a full divide
        run("DIV after DIVU", `ALU_DIV, 32'd100, 32'd7, 5'h0E, 32'd14, 34);
        run("REM after DIV", `ALU_REM, 32'd100, 32'd7, 5'h0F, 32'd2, CL);

        out_ready = 1'b0;
        issue(`ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h13, 32'hFFFFFFFE, 1'b1);
        wait_out("backpressure", 10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold out_valid", 64'(out_valid), 64'(1));
            check("hold result", 64'(result), 64'hFFFFFFFE);
            check("hold out_tag", 64'(out_tag), 64'h13);
            check("hold in_ready", 64'(in_ready), 64'(0));
            check("hold busy", 64'(busy), 64'(1));
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        check("handshake out_valid", 64'(out_valid), 64'(0));
        check("handshake in_ready", 64'(in_ready), 64'(1));

        issue(`ALU_DIV, 32'd1000, 32'd3, 5'h10, 32'd0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush calc busy", 64'(busy), 64'(0));
        check("flush calc in_ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check("flushed no out_valid", 64'(seen), 64'(0));

        @(negedge clk);
        alucode = `ALU_MUL; op1 = 32'd2; op2 = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush idle no accept", 64'(busy), 64'(0));

        issue(`ALU_DIVU, 32'd5, 32'd0, 5'h11, 32'd0, 1'b0);
        check("special out_valid", 64'(out_valid), 64'(1));
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush done out_valid", 64'(out_valid), 64'(0));
        check("flush done in_ready", 64'(in_ready), 64'(1));

        issue(`ALU_MUL, 32'd3, 32'd5, 5'h12, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async rst mid-MUL busy", 64'(busy), 64'(0));
        check("async rst mid-MUL out_valid", 64'(out_valid), 64'(0));
        @(negedge clk) rst = 1'b1;

        out_ready = 1'b0;
        issue(`ALU_MUL, 32'd6, 32'd7, 5'h14, 32'd42, 1'b1);
        wait_out("MUL before rst", 10);
        #2 rst = 1'b0;
        #1 check("async rst done out_valid", 64'(out_valid), 64'(0));
        check("async rst result", 64'(result), 64'(0));
        check("async rst out_tag", 64'(out_tag), 64'(0));
        @(negedge clk) rst = 1'b1;
        out_ready = 1'b1;

        // reset invalidated the cached signed 100/7 entry
        run("REM after reset", `ALU_REM, 32'd100, 32'd7, 5'h15, 32'd2, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
